// File: rtl/matmul_read_scheduler.sv
// Walks every (A row, B column) pair of the loaded matrices and presents them to the dot-product unit.
// Define SCHED_ABORT_EN to add the abort/aborted ports for cancelling a run in progress.
module matmul_read_scheduler #(
    parameter int unsigned ELEM_W       = 8,
    parameter int unsigned DIM          = 32,
    parameter int unsigned READ_LATENCY = 2,
    localparam int unsigned ROW_W       = ELEM_W * DIM,
    localparam int unsigned ADDR_W      = $clog2(DIM),
    localparam int unsigned CNT_W       = $clog2(DIM + 1)
) (
    input  logic              inter_refclk,
    input  logic              rst,
    input  logic              load_complete,
    input  logic [CNT_W-1:0]  n_rows_a,
    input  logic [CNT_W-1:0]  n_cols_b,
    output logic [ADDR_W-1:0] a_rd_addr,
    output logic              a_rd_en,
    input  logic [ROW_W-1:0]  a_rd_data,
    output logic [ADDR_W-1:0] b_rd_addr,
    output logic              b_rd_en,
    input  logic [ROW_W-1:0]  b_rd_data,
    output logic              pair_valid,
    input  logic              pair_ready,
    output logic [ROW_W-1:0]  a_row_out,
    output logic [ROW_W-1:0]  b_col_out,
    output logic [ADDR_W-1:0] row_idx,
    output logic [ADDR_W-1:0] col_idx,
    output logic              busy,
    output logic              done
`ifdef SCHED_ABORT_EN
    ,
    input  logic              abort,
    output logic              aborted
`endif
);

    localparam int unsigned WAIT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, PRESENT, FINISH} state_t;

    state_t            state;
    logic [CNT_W-1:0]  n_rows;
    logic [CNT_W-1:0]  n_cols;
    logic [ADDR_W-1:0] i_cnt;
    logic [ADDR_W-1:0] j_cnt;
    logic [WAIT_W-1:0] wait_cnt;

    logic [CNT_W-1:0]  rows_clamped;
    logic [CNT_W-1:0]  cols_clamped;
    logic              last_col;
    logic              last_row;
    logic [ADDR_W-1:0] next_i;
    logic [ADDR_W-1:0] next_j;

    assign rows_clamped = (n_rows_a > CNT_W'(DIM)) ? CNT_W'(DIM) : n_rows_a;
    assign cols_clamped = (n_cols_b > CNT_W'(DIM)) ? CNT_W'(DIM) : n_cols_b;
    assign last_col     = (CNT_W'(j_cnt) == (n_cols - CNT_W'(1)));
    assign last_row     = (CNT_W'(i_cnt) == (n_rows - CNT_W'(1)));
    // Only consulted when the accepted pair is not the final one, so i never passes DIM-1.
    assign next_j       = last_col ? '0 : j_cnt + ADDR_W'(1);
    assign next_i       = last_col ? i_cnt + ADDR_W'(1) : i_cnt;

    always_ff @(posedge inter_refclk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            n_rows     <= '0;
            n_cols     <= '0;
            i_cnt      <= '0;
            j_cnt      <= '0;
            wait_cnt   <= '0;
            a_rd_addr  <= '0;
            b_rd_addr  <= '0;
            a_rd_en    <= 1'b0;
            b_rd_en    <= 1'b0;
            pair_valid <= 1'b0;
            a_row_out  <= '0;
            b_col_out  <= '0;
            row_idx    <= '0;
            col_idx    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef SCHED_ABORT_EN
            aborted    <= 1'b0;
`endif
        end else begin
            done    <= 1'b0;
            a_rd_en <= 1'b0;
            b_rd_en <= 1'b0;
`ifdef SCHED_ABORT_EN
            aborted <= 1'b0;
            if (abort && (state != IDLE)) begin
                state      <= IDLE;
                pair_valid <= 1'b0;
                busy       <= 1'b0;
                aborted    <= 1'b1;
            end else
`endif
            begin
                case (state)
                    IDLE: begin
                        if (load_complete) begin
                            n_rows <= rows_clamped;
                            n_cols <= cols_clamped;
                            i_cnt  <= '0;
                            j_cnt  <= '0;
                            busy   <= 1'b1;
                            if ((rows_clamped == '0) || (cols_clamped == '0)) begin
                                state <= FINISH;
                            end else begin
                                state     <= ISSUE;
                                a_rd_en   <= 1'b1;
                                b_rd_en   <= 1'b1;
                                a_rd_addr <= '0;
                                b_rd_addr <= '0;
                            end
                        end
                    end
                    ISSUE: begin
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end
                    // The final WAIT cycle is the one in which the buffer output register holds the row.
                    WAIT: begin
                        if (wait_cnt == WAIT_W'(READ_LATENCY - 1)) begin
                            a_row_out  <= a_rd_data;
                            b_col_out  <= b_rd_data;
                            row_idx    <= i_cnt;
                            col_idx    <= j_cnt;
                            pair_valid <= 1'b1;
                            state      <= PRESENT;
                        end else begin
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                    end
                    PRESENT: begin
                        if (pair_ready) begin
                            pair_valid <= 1'b0;
                            if (last_row && last_col) begin
                                state <= FINISH;
                            end else begin
                                i_cnt     <= next_i;
                                j_cnt     <= next_j;
                                a_rd_addr <= next_i;
                                b_rd_addr <= next_j;
                                a_rd_en   <= 1'b1;
                                b_rd_en   <= 1'b1;
                                state     <= ISSUE;
                            end
                        end
                    end
                    FINISH: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_matmul_read_scheduler.sv
// Randomized bench for matmul_read_scheduler: buffer model, expected-pair queue and scoreboard.
module tb_matmul_read_scheduler;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load_complete = 1'b0;
    logic [5:0]   n_rows_a = '0;
    logic [5:0]   n_cols_b = '0;
    logic [4:0]   a_rd_addr, b_rd_addr;
    logic         a_rd_en, b_rd_en;
    logic [255:0] a_rd_data = '0, b_rd_data = '0;
    logic [255:0] a_q1 = '0, b_q1 = '0;
    logic         pair_valid;
    logic         pair_ready = 1'b0;
    logic [255:0] a_row_out, b_col_out;
    logic [4:0]   row_idx, col_idx;
    logic         busy, done;
`ifdef SCHED_ABORT_EN
    logic         abort = 1'b0;
    logic         aborted;
`endif

    matmul_read_scheduler dut (
        .inter_refclk (clk),
        .rst          (rst),
        .load_complete(load_complete),
        .n_rows_a     (n_rows_a),
        .n_cols_b     (n_cols_b),
        .a_rd_addr    (a_rd_addr),
        .a_rd_en      (a_rd_en),
        .a_rd_data    (a_rd_data),
        .b_rd_addr    (b_rd_addr),
        .b_rd_en      (b_rd_en),
        .b_rd_data    (b_rd_data),
        .pair_valid   (pair_valid),
        .pair_ready   (pair_ready),
        .a_row_out    (a_row_out),
        .b_col_out    (b_col_out),
        .row_idx      (row_idx),
        .col_idx      (col_idx),
        .busy         (busy),
        .done         (done)
`ifdef SCHED_ABORT_EN
        ,
        .abort        (abort),
        .aborted      (aborted)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [255:0] mem_a [32];
    logic [255:0] mem_b [32];

    int exp_i[$];
    int exp_j[$];
    int rises[$];
    int busy_cnt = 0, rd_cnt = 0, accepted = 0, done_cnt = 0;
    int done_cyc = 0, last_acc_cyc = 0, load_cyc = 0;
    int last_i = 0, last_j = 0;
    logic         ready_rand = 1'b0;
    logic         ready_force = 1'b0;
    logic         hold = 1'b0;
    logic         prev_valid = 1'b0;
    logic [255:0] h_a, h_b;
    logic [4:0]   h_i, h_j;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Two-cycle buffer: address sampled with the enable, row visible two edges later; junk otherwise.
    always @(posedge clk) begin
        a_q1      <= a_rd_en ? mem_a[a_rd_addr] : rand256();
        b_q1      <= b_rd_en ? mem_b[b_rd_addr] : rand256();
        a_rd_data <= a_q1;
        b_rd_data <= b_q1;
    end

    initial forever begin
        @(posedge clk);
        #2;
        pair_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_force;
    end

    // Scoreboard: every accepted pair must be the next expected (i, j) with matching data.
    always @(negedge clk) begin
        int ei, ej;
        if (rst) begin
            hold       = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (a_rd_en) rd_cnt++;
            if (pair_valid) check("no_read_while_valid", {a_rd_en, b_rd_en}, 0);
            if (hold) begin
                check("hold_valid", pair_valid, 1);
                check("hold_a_row", a_row_out, h_a);
                check("hold_b_col", b_col_out, h_b);
                check("hold_idx", {row_idx, col_idx}, {h_i, h_j});
            end
            if (pair_valid && !prev_valid) rises.push_back(cyc);
            if (pair_valid && pair_ready) begin
                accepted++;
                last_acc_cyc = cyc;
                last_i = row_idx;
                last_j = col_idx;
                if (exp_i.size() == 0) begin
                    check("extra_pair", 1, 0);
                end else begin
                    ei = exp_i.pop_front();
                    ej = exp_j.pop_front();
                    check("row_idx", row_idx, ei);
                    check("col_idx", col_idx, ej);
                    check("a_row_out", a_row_out, mem_a[ei]);
                    check("b_col_out", b_col_out, mem_b[ej]);
                end
            end
            hold = pair_valid && !pair_ready
`ifdef SCHED_ABORT_EN
                   && !abort
`endif
                   ;
            h_a = a_row_out; h_b = b_col_out; h_i = row_idx; h_j = col_idx;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_with_pairs_left", exp_i.size(), 0);
            end
            prev_valid = pair_valid;
        end
    end

    task automatic start(input int r, input int c);
        int rc = (r > 32) ? 32 : r;
        int cc = (c > 32) ? 32 : c;
        for (int i = 0; i < rc; i++)
            for (int j = 0; j < cc; j++) begin
                exp_i.push_back(i);
                exp_j.push_back(j);
            end
        rises.delete();
        busy_cnt = 0; rd_cnt = 0; accepted = 0;
        @(posedge clk); #1;
        n_rows_a = 6'(r); n_cols_b = 6'(c); load_complete = 1'b1; load_cyc = cyc;
        @(posedge clk); #1;
        load_complete = 1'b0;
        n_rows_a = 6'($urandom_range(0, 63)); n_cols_b = 6'($urandom_range(0, 63));
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check("done_timeout", done_cnt != d0, 1);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!pair_valid && n < budget);
        check("valid_timeout", pair_valid, 1);
    endtask

    task automatic rst_checks();
        check("rst_ctrl", {a_rd_en, b_rd_en, pair_valid, busy, done}, 0);
        check("rst_addr_idx", {a_rd_addr, b_rd_addr, row_idx, col_idx}, 0);
        check("rst_a_row", a_row_out, 0);
        check("rst_b_col", b_col_out, 0);
    endtask

    initial begin
        int d0;
        for (int k = 0; k < 32; k++) begin
            mem_a[k] = rand256();
            mem_b[k] = rand256();
        end
        repeat (3) @(posedge clk);
        #1 rst_checks();
        rst = 1'b0;

        // 2x3, always ready: order, data, 4-cycle spacing, latency and single done
        ready_force = 1'b1;
        start(2, 3);
        wait_done(200);
        check("t1_pairs", accepted, 6);
        check("t1_rises", rises.size(), 6);
        if (rises.size() > 0) check("t1_first_latency", rises[0] - load_cyc, 4);
        for (int k = 1; k < rises.size(); k++) check("t1_rise_gap", rises[k] - rises[k-1], 4);
        check("t1_done_after_accept", done_cyc - last_acc_cyc, 2);
        check("t1_busy_cycles", busy_cnt, 25);
        check("t1_reads", rd_cnt, 6);

        // Backpressure: pair (0,1) held for several cycles with ready low
        ready_force = 1'b0;
        start(2, 3);
        for (int p = 0; p < 6; p++) begin
            wait_valid(40);
            if (p == 1) repeat (5) @(posedge clk);
            @(posedge clk); #1 ready_force = 1'b1;
            @(posedge clk); #1 ready_force = 1'b0;
        end
        wait_done(40);
        check("t2_pairs", accepted, 6);
        check("t2_reads", rd_cnt, 6);

        // Zero rows: no reads, done two cycles after the start pulse
        ready_force = 1'b1;
        start(0, 5);
        wait_done(20);
        check("t3_reads", rd_cnt, 0);
        check("t3_done_latency", done_cyc - load_cyc, 2);
        check("t3_busy_cycles", busy_cnt, 1);
        check("t3_pairs", accepted, 0);

        // Oversized dimensions clamp to 32x32 under random backpressure
        ready_rand = 1'b1;
        d0 = done_cnt;
        start(40, 32);
        wait_done(30000);
        check("t4_pairs", accepted, 1024);
        check("t4_last_idx", {8'(last_i), 8'(last_j)}, {8'd31, 8'd31});
        check("t4_done_once", done_cnt - d0, 1);

        // A few random shapes
        for (int k = 0; k < 3; k++) begin
            start($urandom_range(1, 6), $urandom_range(1, 6));
            wait_done(500);
        end

        // Second start pulse while busy is ignored
        ready_rand = 1'b0;
        ready_force = 1'b1;
        d0 = done_cnt;
        start(2, 2);
        repeat (3) @(posedge clk);
        #1 n_rows_a = 6'd5; n_cols_b = 6'd5; load_complete = 1'b1;
        @(posedge clk); #1 load_complete = 1'b0;
        wait_done(100);
        repeat (10) @(posedge clk);
        check("t5_pairs", accepted, 4);
        check("t5_done_once", done_cnt - d0, 1);

        // Asynchronous reset in WAIT of the second pair
        start(3, 3);
        begin
            int n = 0;
            do begin
                @(negedge clk); #1;
                n++;
            end while (!(a_rd_en && b_rd_addr == 5'd1) && n < 50);
            check("t6_issue_seen", a_rd_en, 1);
        end
        @(posedge clk); #2;
        d0 = done_cnt;
        rst = 1'b1;
        #1 rst_checks();
        exp_i.delete();
        exp_j.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        check("t6_no_done", done_cnt, d0);
        ready_rand = 1'b1;
        start(3, 2);
        wait_done(300);
        check("t6_restart_pairs", accepted, 6);

`ifdef SCHED_ABORT_EN
        // Abort while presenting (1,2)
        ready_rand = 1'b0;
        ready_force = 1'b0;
        start(2, 3);
        for (int p = 0; p < 6; p++) begin
            wait_valid(40);
            if (p < 5) begin
                @(posedge clk); #1 ready_force = 1'b1;
                @(posedge clk); #1 ready_force = 1'b0;
            end
        end
        check("ab_idx", {row_idx, col_idx}, {5'd1, 5'd2});
        d0 = done_cnt;
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1;
        check("ab_pulse", aborted, 1);
        check("ab_state", {pair_valid, busy, a_rd_en}, 0);
        abort = 1'b0;
        exp_i.delete();
        exp_j.delete();
        @(posedge clk); #1;
        check("ab_pulse_once", aborted, 0);
        repeat (5) @(posedge clk);
        check("ab_no_done", done_cnt, d0);
        ready_force = 1'b1;
        start(2, 3);
        wait_done(200);
        check("ab_clean_pairs", accepted, 6);
`endif

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matmul_read_scheduler.md
Name: matmul_read_scheduler

Overview:
- Sequences reads from the two matrix row/column buffers filled by the Ethernet loader, after the loader signals load complete.
- Walks every (A row i, B column j) pair in row-major order: i outer, j inner.
- Presents each 256-bit row/column pair to the downstream dot-product unit over a valid/ready handshake.
- Runs entirely in the compute clock domain and is the sole read-port owner of both buffers.

Parameters:
- ELEM_W, 8, bits per matrix element.
- DIM, 32, maximum rows of A and maximum columns of B.
- READ_LATENCY, 2, buffer read latency in cycles (high-performance BRAM: enb plus regceb).
- ROW_W, ELEM_W*DIM = 256, row/column vector width.
- ADDR_W, $clog2(DIM) = 5, buffer address width.
- CNT_W, $clog2(DIM+1) = 6, dimension count width.

Ports:
- inter_refclk  in  1  compute clock, the only clock.
- rst  in  1  asynchronous, active-high reset.
- load_complete  in  1  single-cycle pulse from the loader: both buffers valid.
- n_rows_a  in  CNT_W  active rows of A; sampled on the start pulse.
- n_cols_b  in  CNT_W  active columns of B; sampled on the start pulse.
- a_rd_addr  out  ADDR_W  A buffer read address.
- a_rd_en  out  1  A buffer read enable (drives enb and regceb).
- a_rd_data  in  ROW_W  A buffer read data.
- b_rd_addr  out  ADDR_W  B buffer read address.
- b_rd_en  out  1  B buffer read enable.
- b_rd_data  in  ROW_W  B buffer read data.
- pair_valid  out  1  a_row_out and b_col_out hold a valid pair.
- pair_ready  in  1  downstream accepts the pair.
- a_row_out  out  ROW_W  registered A row.
- b_col_out  out  ROW_W  registered B column.
- row_idx  out  ADDR_W  i of the presented pair.
- col_idx  out  ADDR_W  j of the presented pair.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last pair is accepted.

Behaviour:
- Reset: all outputs 0; state IDLE; counters and dimension registers 0.
- States: IDLE, ISSUE, WAIT, PRESENT, FINISH.
- IDLE: on load_complete, latch the dimensions, clamping each to DIM.
  - If either latched dimension is 0: go to FINISH with no pairs issued.
  - Otherwise: i=0, j=0, go to ISSUE.
- ISSUE (1 cycle): a_rd_en=b_rd_en=1, a_rd_addr=i, b_rd_addr=j; go to WAIT.
- Enables are 1 only in ISSUE. Addresses hold their last value otherwise.
- WAIT: count READ_LATENCY-1 cycles.
  - The next edge captures a_rd_data and b_rd_data into the output registers.
  - Set pair_valid=1 and row_idx=i, col_idx=j; go to PRESENT.
  - First pair_valid therefore appears READ_LATENCY+1 cycles after the ISSUE cycle.
- PRESENT: outputs stable while pair_valid && !pair_ready.
  - On pair_valid && pair_ready: drop pair_valid next cycle.
  - If j==n_cols_b-1: j=0, i=i+1; otherwise j=j+1.
  - If the accepted pair was (n_rows_a-1, n_cols_b-1): go to FINISH; otherwise go to ISSUE.
- FINISH: done=1 for exactly one cycle, then IDLE. busy deasserts in the same cycle IDLE is entered.
- Throughput without the optional feature: one pair per READ_LATENCY+2 cycles when pair_ready is held high.
- load_complete while not IDLE: ignored, including in FINISH. Dimension registers do not change.
- Dimension inputs may change freely after the start pulse.
- pair_ready while pair_valid=0: ignored.
- Asynchronous reset mid-operation: immediate return to IDLE.
  - pair_valid and done clear at once.
  - In-flight read data is discarded; no done pulse is produced.
- Counters never exceed DIM-1. No wrap beyond the latched dimensions.

Optional Feature:
- Macro: SCHED_ABORT_EN.
- With the macro defined, the block adds two ports:
  - abort  in  1  synchronous abort request.
  - aborted  out  1  one-cycle pulse acknowledging the abort.
- abort high in any non-IDLE state:
  - Next cycle: state IDLE, pair_valid=0, a_rd_en=b_rd_en=0, aborted=1 for one cycle.
  - No done pulse; the pending read result is dropped.
- abort in IDLE: no effect, no aborted pulse.
- abort and load_complete in the same IDLE cycle: the start wins.
- Without the macro, neither port exists and behaviour is as above.

Test Plan:
- n_rows_a=2, n_cols_b=3, pair_ready held 1: 6 pairs in order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); each a_row_out equals A[i] and each b_col_out equals B[j]; consecutive pair_valid rising edges are 4 cycles apart; one done pulse after the sixth acceptance.
- Backpressure: pair_ready low for 5 cycles on pair (0,1): a_row_out, b_col_out and indices stay stable; no new read issued; the sequence resumes correctly.
- n_rows_a=0, n_cols_b=5: no a_rd_en ever; done pulses 2 cycles after load_complete; busy high for exactly those cycles.
- n_rows_a=40, n_cols_b=32: clamped to 32x32; exactly 1024 pairs; last indices (31,31); done once.
- Second load_complete mid-run, then rst asserted mid-WAIT: the second pulse has no effect; rst clears all outputs immediately with no done pulse; a following load_complete restarts from (0,0).
- SCHED_ABORT_EN: abort during PRESENT of pair (1,2): aborted pulse next cycle, pair_valid 0, no done; a following load_complete runs a clean full sequence.
